w_ptr_full_ctrl: RTL and testbench

Write-side pointer and full-flag controller for the asynchronous FIFO, owned by the write clock domain. It advances the binary write pointer on accepted writes and supplies the dual-port RAM write address and write strobe. It exports the Gray-coded write pointer to the read domain. It synchronizes the read domain's Gray pointer to derive registered full, almost-full, fill-level and sticky overflow status.

---
 rtl/w_ptr_full_ctrl_pkg.sv | 20 ++
 rtl/binary_to_gray.sv | 11 +
 rtl/d_ff_async.sv | 16 +
 rtl/two_ff_synchronizer.sv | 23 ++
 rtl/w_ptr_full_ctrl_gray_to_binary.sv | 13 +
 rtl/w_ptr_full_ctrl.sv | 99 +++++++++
 tb/tb_w_ptr_full_ctrl.sv | 176 +++++++++++++++++
 7 files changed

// File: rtl/w_ptr_full_ctrl_pkg.sv
// Shared constants and pointer helpers for the asynchronous FIFO.
// Both clock domains import this package.
package w_ptr_full_ctrl_pkg;

  localparam int unsigned ADDRESS_SIZE_DEF = 4;
  localparam int unsigned DEPTH_DEF        = 1 << ADDRESS_SIZE_DEF;

  // Each binary bit is the XOR of all Gray bits at or above it.
  // Inputs narrower than 32 bits are zero-extended, so one function
  // covers every pointer width up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to Gray code conversion.
module binary_to_gray #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/d_ff_async.sv
// Register of width W with an asynchronous active-low clear.
module d_ff_async #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= '0;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/two_ff_synchronizer.sv
// Two-flop synchronizer for a Gray-coded bus crossing into clk_i.
module two_ff_synchronizer #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/w_ptr_full_ctrl_gray_to_binary.sv
// Combinational Gray to binary conversion; counterpart of binary_to_gray.
module gray_to_binary
  import w_ptr_full_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  assign bin_o = N'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/w_ptr_full_ctrl.sv
// Write-side pointer, RAM strobe and full/almost-full/level/overflow status
// for the asynchronous FIFO, clocked by w_clk.
module w_ptr_full_ctrl
  import w_ptr_full_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE    = ADDRESS_SIZE_DEF,
  parameter int unsigned AFULL_THRESHOLD = 2
) (
  input  logic                    w_clk,
  input  logic                    wrst_n,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE:0]   r_ptr,
  output logic                    w_inc,
  output logic [ADDRESS_SIZE-1:0] w_addr,
  output logic [ADDRESS_SIZE:0]   w_ptr,
  output logic                    w_full,
  output logic                    w_almost_full,
  output logic [ADDRESS_SIZE:0]   w_level,
  output logic                    w_overflow
);

  localparam int unsigned PW = ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(1) << ADDRESS_SIZE;
  localparam logic [PW-1:0] THR_P   = PW'(AFULL_THRESHOLD);

  logic [PW-1:0] w_bin_q, w_bin_d;
  logic [PW-1:0] w_ptr_q, w_gnext;
  logic [PW-1:0] wq2_rptr, rbin_sync;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  // Gated by reset so the RAM is never strobed while the block is held.
  assign w_inc   = w_en & ~full_q & wrst_n;
  assign w_bin_d = w_bin_q + PW'(w_inc);

  binary_to_gray #(.N(PW)) u_b2g (
    .bin_i  (w_bin_d),
    .gray_o (w_gnext)
  );

  d_ff_async #(.W(PW)) u_bin_ff (
    .clk_i  (w_clk),
    .rst_ni (wrst_n),
    .d_i    (w_bin_d),
    .q_o    (w_bin_q)
  );

  d_ff_async #(.W(PW)) u_ptr_ff (
    .clk_i  (w_clk),
    .rst_ni (wrst_n),
    .d_i    (w_gnext),
    .q_o    (w_ptr_q)
  );

  two_ff_synchronizer #(.W(PW)) u_rptr_sync (
    .clk_i  (w_clk),
    .rst_ni (wrst_n),
    .d_i    (r_ptr),
    .q_o    (wq2_rptr)
  );

  gray_to_binary #(.N(PW)) u_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin_sync)
  );

  // Full when the next Gray pointer has lapped the synced read pointer:
  // top two Gray bits inverted, the rest equal.
  always_comb begin
    full_d  = (w_gnext == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
    level_d = w_bin_d - rbin_sync;
    afull_d = ((DEPTH_P - level_d) <= THR_P);
    ovf_d   = ovf_q | (w_en & full_q);
  end

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_addr        = w_bin_q[ADDRESS_SIZE-1:0];
  assign w_ptr         = w_ptr_q;
  assign w_full        = full_q;
  assign w_almost_full = afull_q;
  assign w_level       = level_q;
  assign w_overflow    = ovf_q;

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
// Directed bench for w_ptr_full_ctrl with ADDRESS_SIZE=4, AFULL_THRESHOLD=2.
module tb_w_ptr_full_ctrl;

  logic       w_clk = 1'b0;
  logic       wrst_n;
  logic       w_en;
  logic [4:0] r_ptr;
  logic       w_inc;
  logic [3:0] w_addr;
  logic [4:0] w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [4:0] w_level;
  logic       w_overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  w_ptr_full_ctrl #(.ADDRESS_SIZE(4), .AFULL_THRESHOLD(2)) dut (
    .w_clk         (w_clk),
    .wrst_n        (wrst_n),
    .w_en          (w_en),
    .r_ptr         (r_ptr),
    .w_inc         (w_inc),
    .w_addr        (w_addr),
    .w_ptr         (w_ptr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic full, input logic afull,
                            input logic [4:0] lvl);
    chk({tag, ".full"},  32'(w_full), 32'(full));
    chk({tag, ".afull"}, 32'(w_almost_full), 32'(afull));
    chk({tag, ".level"}, 32'(w_level), 32'(lvl));
  endtask

  initial begin
    int unsigned b;
    logic [4:0]  g, prev_g;

    // Reset held with a write request pending
    wrst_n = 1'b0;
    w_en   = 1'b1;
    r_ptr  = 5'b0;
    tick();
    tick();
    chk("rst.w_inc", 32'(w_inc), 0);
    chk("rst.w_addr", 32'(w_addr), 0);
    chk("rst.w_ptr", 32'(w_ptr), 0);
    chk("rst.ovf", 32'(w_overflow), 0);
    chk_status("rst", 1'b0, 1'b0, 5'd0);
    w_en   = 1'b0;
    wrst_n = 1'b1;
    tick();

    // Fill 16 slots with the read pointer parked at 0
    for (int k = 0; k < 16; k++) begin
      w_en = 1'b1;
      #1;
      chk($sformatf("fill%0d.addr", k), 32'(w_addr), 32'(k));
      chk($sformatf("fill%0d.inc", k), 32'(w_inc), 1);
      tick();
      chk_status($sformatf("fill%0d", k), (k + 1 == 16), (k + 1 >= 14), 5'(k + 1));
    end
    w_en = 1'b0;
    chk("fill.w_ptr", 32'(w_ptr), 32'(5'b11000));
    chk("fill.ovf", 32'(w_overflow), 0);

    // Writes while full are dropped and set the sticky overflow
    w_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ovf%0d.inc", k), 32'(w_inc), 0);
      tick();
      chk($sformatf("ovf%0d.w_ptr", k), 32'(w_ptr), 32'(5'b11000));
      chk($sformatf("ovf%0d.addr", k), 32'(w_addr), 0);
      chk($sformatf("ovf%0d.ovf", k), 32'(w_overflow), 1);
    end
    w_en = 1'b0;
    tick();
    chk("ovf.sticky", 32'(w_overflow), 1);

    // One read released: visible on the third edge
    r_ptr = 5'b00001;
    tick();
    chk_status("rel.e1", 1'b1, 1'b1, 5'd16);
    tick();
    chk_status("rel.e2", 1'b1, 1'b1, 5'd16);
    tick();
    chk_status("rel.e3", 1'b0, 1'b1, 5'd15);

    // Refill the freed slot, then release another read while writing
    w_en = 1'b1;
    #1;
    chk("sim.pre.inc", 32'(w_inc), 1);
    tick();
    w_en = 1'b0;
    chk_status("sim.pre", 1'b1, 1'b1, 5'd16);
    chk("sim.pre.addr", 32'(w_addr), 1);
    r_ptr = 5'b00011;
    w_en  = 1'b1;
    tick();
    chk("sim.e1.full", 32'(w_full), 1);
    chk("sim.e1.inc", 32'(w_inc), 0);
    tick();
    chk("sim.e2.full", 32'(w_full), 1);
    chk("sim.e2.addr", 32'(w_addr), 1);
    chk("sim.e2.inc", 32'(w_inc), 0);
    tick();
    chk_status("sim.e3", 1'b0, 1'b1, 5'd15);
    chk("sim.e3.addr", 32'(w_addr), 1);
    chk("sim.e3.inc", 32'(w_inc), 1);
    tick();
    w_en = 1'b0;
    chk_status("sim.e4", 1'b1, 1'b1, 5'd16);
    chk("sim.e4.addr", 32'(w_addr), 2);
    chk("sim.e4.w_ptr", 32'(w_ptr), 32'(5'b11011));

    // Asynchronous reset mid-cycle clears without a clock edge
    @(posedge w_clk);
    #3;
    wrst_n = 1'b0;
    #1;
    chk("arst.w_ptr", 32'(w_ptr), 0);
    chk("arst.addr", 32'(w_addr), 0);
    chk("arst.ovf", 32'(w_overflow), 0);
    chk("arst.inc", 32'(w_inc), 0);
    chk_status("arst", 1'b0, 1'b0, 5'd0);
    r_ptr = 5'b0;
    tick();
    wrst_n = 1'b1;
    tick();

    // Wrap: one write, then let the read pointer catch up
    b      = 0;
    prev_g = 5'b0;
    for (int i = 0; i < 40; i++) begin
      w_en = 1'b1;
      tick();
      w_en = 1'b0;
      b = (b + 1) % 32;
      g = 5'(b) ^ (5'(b) >> 1);
      chk($sformatf("wrap%0d.w_ptr", i), 32'(w_ptr), 32'(g));
      chk($sformatf("wrap%0d.onebit", i), $countones(w_ptr ^ prev_g), 1);
      chk($sformatf("wrap%0d.addr", i), 32'(w_addr), b % 16);
      chk_status($sformatf("wrap%0d", i), 1'b0, 1'b0, 5'd1);
      r_ptr = g;
      repeat (3) tick();
      chk($sformatf("wrap%0d.drain", i), 32'(w_level), 0);
      prev_g = g;
    end
    chk("wrap.ovf", 32'(w_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
